// File: rtl/known_ch_pkg.sv
// Shared widths, the "no cluster head" marker and the table entry layout
// used by the known-CH tracker and its best-entry selector.
package known_ch_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int MAX_CH     = 16;

    localparam logic [WORD_WIDTH-1:0] NO_CH = 16'hFFFF;

    typedef struct packed {
        logic                  valid;
        logic [WORD_WIDTH-1:0] id;
        logic [WORD_WIDTH-1:0] hops;
        logic [WORD_WIDTH-1:0] q;
    } ch_entry_t;

endpackage

// File: rtl/known_ch_best_sel.sv
// Combinational pick of the best valid entry: highest Q, then fewest hops,
// then lowest slot index.
module known_ch_best_sel
    import known_ch_pkg::*;
#(
    parameter int N = known_ch_pkg::MAX_CH
) (
    input  ch_entry_t [N-1:0]      i_entries,
    output logic                   o_found,
    output logic [WORD_WIDTH-1:0]  o_id,
    output logic [WORD_WIDTH-1:0]  o_hops
);

    logic [WORD_WIDTH-1:0] w_best_q;

    // Strict comparisons keep the earlier slot on a full tie.
    always_comb begin
        o_found  = 1'b0;
        o_id     = NO_CH;
        o_hops   = NO_CH;
        w_best_q = '0;
        for (int i = 0; i < N; i++) begin
            if (i_entries[i].valid &&
                (!o_found ||
                 (i_entries[i].q > w_best_q) ||
                 ((i_entries[i].q == w_best_q) && (i_entries[i].hops < o_hops)))) begin
                o_found  = 1'b1;
                o_id     = i_entries[i].id;
                o_hops   = i_entries[i].hops;
                w_best_q = i_entries[i].q;
            end
        end
    end

endmodule

// File: rtl/known_ch_v3.sv
// Known cluster-head table: collects advertised CHs up to a per-round limit
// and registers the best one (ID and hop count) every cycle.
module known_ch_v3
    import known_ch_pkg::*;
#(
    parameter int WORD_WIDTH = known_ch_pkg::WORD_WIDTH,
    parameter int MAX_CH     = known_ch_pkg::MAX_CH
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en_KCH,
    input  logic                  HB_reset,
    input  logic [WORD_WIDTH-1:0] HB_CHlimit,
    input  logic [WORD_WIDTH-1:0] fCH_ID,
    input  logic [WORD_WIDTH-1:0] fCH_Hops,
    input  logic [WORD_WIDTH-1:0] fCH_QValue,
    output logic [WORD_WIDTH-1:0] chosenCH,
    output logic [WORD_WIDTH-1:0] hopsfromCH
);

    localparam int CW = $clog2(MAX_CH + 1);
    localparam int IW = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;

    ch_entry_t [MAX_CH-1:0] r_tab;
    logic [CW-1:0]          r_count;
    logic [CW-1:0]          r_limit;
    logic [WORD_WIDTH-1:0]  r_chosen;
    logic [WORD_WIDTH-1:0]  r_hops;

    logic                   w_hit;
    logic [IW-1:0]          w_hit_idx;
    logic                   w_free;
    logic [IW-1:0]          w_free_idx;
    logic [CW-1:0]          w_lim_clamped;
    logic                   w_found;
    logic [WORD_WIDTH-1:0]  w_best_id;
    logic [WORD_WIDTH-1:0]  w_best_hops;

    assign w_lim_clamped = (HB_CHlimit > WORD_WIDTH'(MAX_CH)) ? CW'(MAX_CH)
                                                              : HB_CHlimit[CW-1:0];

    // Scan downwards so the lowest matching / lowest free slot is the one kept.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (r_tab[i].valid && (r_tab[i].id == fCH_ID)) begin
                w_hit     = 1'b1;
                w_hit_idx = IW'(i);
            end
            if (!r_tab[i].valid) begin
                w_free     = 1'b1;
                w_free_idx = IW'(i);
            end
        end
    end

    known_ch_best_sel #(
        .N (MAX_CH)
    ) u_best_sel (
        .i_entries (r_tab),
        .o_found   (w_found),
        .o_id      (w_best_id),
        .o_hops    (w_best_hops)
    );

    always_ff @(posedge clk) begin
        if (nrst) begin
            for (int i = 0; i < MAX_CH; i++) r_tab[i].valid <= 1'b0;
            r_count  <= '0;
            r_limit  <= '0;
            r_chosen <= NO_CH;
            r_hops   <= NO_CH;
        end else if (HB_reset) begin
            // New round: the fCH_* sample of this cycle is intentionally dropped.
            for (int i = 0; i < MAX_CH; i++) r_tab[i].valid <= 1'b0;
            r_count  <= '0;
            r_limit  <= w_lim_clamped;
            r_chosen <= NO_CH;
            r_hops   <= NO_CH;
        end else begin
            r_chosen <= w_found ? w_best_id   : NO_CH;
            r_hops   <= w_found ? w_best_hops : NO_CH;
            if (en_KCH) begin
                if (w_hit) begin
                    r_tab[w_hit_idx].hops <= fCH_Hops;
                    r_tab[w_hit_idx].q    <= fCH_QValue;
                end else if ((r_count < r_limit) && w_free) begin
                    r_tab[w_free_idx] <= '{valid: 1'b1, id: fCH_ID,
                                           hops: fCH_Hops, q: fCH_QValue};
                    r_count           <= r_count + 1'b1;
                end
            end
        end
    end

    assign chosenCH   = r_chosen;
    assign hopsfromCH = r_hops;

endmodule

// File: tb/tb_known_ch_v3.sv
// Scenario tasks plus a randomized run against a table-level reference model.
module tb_known_ch_v3;

    logic        clk = 1'b0;
    logic        nrst, en_KCH, HB_reset;
    logic [15:0] HB_CHlimit, fCH_ID, fCH_Hops, fCH_QValue;
    logic [15:0] chosenCH, hopsfromCH;

    int errors = 0;
    int checks = 0;

    // Reference model: a flat list of stored CHs in slot order.
    bit          m_valid [16];
    int unsigned m_id    [16];
    int unsigned m_hops  [16];
    int unsigned m_q     [16];
    int unsigned m_limit;
    logic [15:0] m_ch, m_hp;

    known_ch_v3 dut (
        .clk        (clk),
        .nrst       (nrst),
        .en_KCH     (en_KCH),
        .HB_reset   (HB_reset),
        .HB_CHlimit (HB_CHlimit),
        .fCH_ID     (fCH_ID),
        .fCH_Hops   (fCH_Hops),
        .fCH_QValue (fCH_QValue),
        .chosenCH   (chosenCH),
        .hopsfromCH (hopsfromCH)
    );

    always #5 clk = ~clk;

    function automatic int m_stored();
        int n = 0;
        for (int i = 0; i < 16; i++) if (m_valid[i]) n++;
        return n;
    endfunction

    // Best = maximum of a composite score (Q, then fewer hops, then lower slot).
    task automatic m_select(output logic [15:0] id, output logic [15:0] hp);
        longint best = -1;
        longint score;
        id = 16'hFFFF;
        hp = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            if (m_valid[i]) begin
                score = (longint'(m_q[i]) << 21) + (longint'(65535 - m_hops[i]) << 5) + (31 - i);
                if (score > best) begin
                    best = score;
                    id   = m_id[i][15:0];
                    hp   = m_hops[i][15:0];
                end
            end
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    task automatic m_edge(bit r, bit hb, bit en, int unsigned lim,
                          int unsigned id, int unsigned hp, int unsigned qv);
        int slot;
        if (r) begin
            m_clear(); m_limit = 0; m_ch = 16'hFFFF; m_hp = 16'hFFFF;
        end else if (hb) begin
            m_clear(); m_limit = (lim > 16) ? 16 : lim; m_ch = 16'hFFFF; m_hp = 16'hFFFF;
        end else begin
            m_select(m_ch, m_hp);
            if (en) begin
                slot = -1;
                for (int i = 0; i < 16; i++) if (m_valid[i] && m_id[i] == id) slot = i;
                if (slot >= 0) begin
                    m_hops[slot] = hp; m_q[slot] = qv;
                end else if (m_stored() < int'(m_limit)) begin
                    for (int i = 15; i >= 0; i--) if (!m_valid[i]) slot = i;
                    m_valid[slot] = 1'b1; m_id[slot] = id; m_hops[slot] = hp; m_q[slot] = qv;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the clock, update the model, sample at +1.
    task automatic step(bit r, bit hb, bit en, int unsigned lim,
                        int unsigned id, int unsigned hp, int unsigned qv);
        nrst = r; HB_reset = hb; en_KCH = en;
        HB_CHlimit = lim[15:0]; fCH_ID = id[15:0]; fCH_Hops = hp[15:0]; fCH_QValue = qv[15:0];
        @(posedge clk);
        m_edge(r, hb, en, lim, id, hp, qv);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ins(int unsigned id, int unsigned hp, int unsigned qv);
        step(0, 0, 1, 0, id, hp, qv);
    endtask

    task automatic hb(int unsigned lim);
        step(0, 1, 0, lim, 0, 0, 0);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (chosenCH !== 16'hFFFF || hopsfromCH !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_out got %h/%h want ffff/ffff", chosenCH, hopsfromCH);
        end
        ins(23, 2, 16'h3000);
        ins(24, 1, 16'h3800);
        idle();
        checks++;
        if (chosenCH !== 16'hFFFF || hopsfromCH !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_no_limit got %h/%h want ffff/ffff", chosenCH, hopsfromCH);
        end
    endtask

    task automatic test_basic_insert();
        hb(3);
        checks++;
        if (chosenCH !== 16'hFFFF) begin
            errors++;
            $display("FAIL hb_out got %h want ffff", chosenCH);
        end
        ins(23, 2, 16'h3000);
        ins(23, 2, 16'h3000);
        checks++;
        if (chosenCH !== 16'd23 || hopsfromCH !== 16'd2) begin
            errors++;
            $display("FAIL basic_first got %0d/%0d want 23/2", chosenCH, hopsfromCH);
        end
        ins(45, 2, 16'h2000);
        idle();
        checks++;
        if (chosenCH !== 16'd23 || hopsfromCH !== 16'd2) begin
            errors++;
            $display("FAIL basic_second got %0d/%0d want 23/2", chosenCH, hopsfromCH);
        end
        // Count is 2 after the idempotent repeat: one slot left, then full.
        ins(50, 7, 16'h3100);
        ins(51, 1, 16'h3F00);
        idle();
        checks++;
        if (chosenCH !== 16'd50 || hopsfromCH !== 16'd7) begin
            errors++;
            $display("FAIL basic_count got %0d/%0d want 50/7", chosenCH, hopsfromCH);
        end
    endtask

    task automatic test_tie_break();
        hb(5);
        ins(10, 3, 16'h2000);
        ins(11, 1, 16'h2000);
        idle();
        checks++;
        if (chosenCH !== 16'd11 || hopsfromCH !== 16'd1) begin
            errors++;
            $display("FAIL tie_hops got %0d/%0d want 11/1", chosenCH, hopsfromCH);
        end
        ins(9, 1, 16'h2000);
        idle();
        checks++;
        if (chosenCH !== 16'd11 || hopsfromCH !== 16'd1) begin
            errors++;
            $display("FAIL tie_slot got %0d/%0d want 11/1", chosenCH, hopsfromCH);
        end
    endtask

    task automatic test_limit_full();
        hb(2);
        ins(1, 4, 16'h1000);
        ins(2, 4, 16'h1800);
        ins(3, 4, 16'h3F00);
        idle();
        checks++;
        if (chosenCH !== 16'd2 || hopsfromCH !== 16'd4) begin
            errors++;
            $display("FAIL limit_full got %0d/%0d want 2/4", chosenCH, hopsfromCH);
        end
        hb(0);
        ins(5, 1, 16'h4000);
        ins(6, 1, 16'h4000);
        idle();
        checks++;
        if (chosenCH !== 16'hFFFF || hopsfromCH !== 16'hFFFF) begin
            errors++;
            $display("FAIL limit_zero got %h/%h want ffff/ffff", chosenCH, hopsfromCH);
        end
        hb(100);
        for (int k = 0; k < 17; k++) ins(100 + k, k, 16'h0100 * (k + 1));
        idle();
        checks++;
        if (chosenCH !== 16'd115 || hopsfromCH !== 16'd15) begin
            errors++;
            $display("FAIL limit_clamp got %0d/%0d want 115/15", chosenCH, hopsfromCH);
        end
    endtask

    task automatic test_update_priority();
        hb(4);
        ins(23, 2, 16'h3000);
        ins(45, 2, 16'h2000);
        ins(23, 2, 16'h0800);
        idle();
        checks++;
        if (chosenCH !== 16'd45 || hopsfromCH !== 16'd2) begin
            errors++;
            $display("FAIL update got %0d/%0d want 45/2", chosenCH, hopsfromCH);
        end
        step(0, 1, 1, 4, 77, 1, 16'h4000);
        checks++;
        if (chosenCH !== 16'hFFFF || hopsfromCH !== 16'hFFFF) begin
            errors++;
            $display("FAIL hb_with_en got %h/%h want ffff/ffff", chosenCH, hopsfromCH);
        end
        idle();
        checks++;
        if (chosenCH !== 16'hFFFF || hopsfromCH !== 16'hFFFF) begin
            errors++;
            $display("FAIL hb_dropped got %h/%h want ffff/ffff", chosenCH, hopsfromCH);
        end
        hb(4);
        hb(4);
        idle();
        checks++;
        if (chosenCH !== 16'hFFFF) begin
            errors++;
            $display("FAIL hb_held got %h want ffff", chosenCH);
        end
        ins(30, 3, 16'h1234);
        step(1, 1, 1, 4, 31, 1, 16'h4000);
        ins(32, 1, 16'h4000);
        idle();
        checks++;
        if (chosenCH !== 16'hFFFF || hopsfromCH !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_mid got %h/%h want ffff/ffff", chosenCH, hopsfromCH);
        end
    endtask

    task automatic test_random();
        int unsigned r, h, e, lim, id, hp, qv;
        step(1, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(0, 199) == 0);
            h   = ($urandom_range(0, 24) == 0);
            e   = ($urandom_range(0, 3) != 0);
            lim = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 20);
            id  = $urandom_range(0, 24);
            hp  = $urandom_range(0, 3);
            qv  = ($urandom_range(0, 1) != 0) ? 16'h1000 * $urandom_range(0, 4) : $urandom_range(0, 65535);
            step(r[0], h[0], e[0], lim, id, hp, qv);
            checks++;
            if (chosenCH !== m_ch || hopsfromCH !== m_hp) begin
                errors++;
                $display("FAIL random cycle %0d got %h/%h want %h/%h", n, chosenCH, hopsfromCH, m_ch, m_hp);
            end
        end
    endtask

    initial begin
        nrst = 1'b1; en_KCH = 1'b0; HB_reset = 1'b0;
        HB_CHlimit = '0; fCH_ID = '0; fCH_Hops = '0; fCH_QValue = '0;
        m_clear(); m_limit = 0; m_ch = 16'hFFFF; m_hp = 16'hFFFF;
        test_reset();
        test_basic_insert();
        test_tie_break();
        test_limit_full();
        test_update_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/known_ch_v3.md
KNOWN_CH_V3 -- requirements
Module: known_ch_v3

Interface
REQ-001 Parameters SHALL be: WORD_WIDTH, default 16, data word width; MAX_CH, default 16, table depth.
REQ-002 Ports SHALL be: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Ports SHALL be: nrst  in  1  reset, synchronous and active-high (1 = reset).
REQ-004 Ports SHALL be: en_KCH  in  1  sample fCH_* this cycle.
REQ-005 Ports SHALL be: HB_reset  in  1  heartbeat received; clear table and latch limit.
REQ-006 Ports SHALL be: HB_CHlimit  in  16  maximum cluster heads (CHs) to track this round.
REQ-007 Ports SHALL be: fCH_ID  in  16  advertised cluster-head (CH) ID.
REQ-008 Ports SHALL be: fCH_Hops  in  16  hops to that CH.
REQ-009 Ports SHALL be: fCH_QValue  in  16  CH Q-value, unsigned Q2.14 (0x4000 = 1.0).
REQ-010 Ports SHALL be: chosenCH  out  16  ID of best known CH; 0xFFFF = none.
REQ-011 Ports SHALL be: hopsfromCH  out  16  hops of chosenCH; 0xFFFF = none.

Function
REQ-012 The block SHALL hold up to MAX_CH entries {valid, ID, hops, Q}, plus a count and a latched limit register.
REQ-013 HB_reset=1 SHALL, at the edge:
  - clear all valid bits and the count;
  - latch limit = min(HB_CHlimit, MAX_CH);
  - set both outputs to 0xFFFF.
REQ-014 When en_KCH=1 and HB_reset=0, and fCH_ID matches a valid entry, the block SHALL overwrite that entry's hops and Q; the count SHALL NOT change.
REQ-015 Otherwise, when en_KCH=1, HB_reset=0 and count < limit, the block SHALL write the CH into the lowest invalid slot and increment the count.
REQ-016 When en_KCH=1, HB_reset=0, there is no ID match and count >= limit (including limit 0), the new CH SHALL be ignored.
REQ-017 en_KCH held for several cycles with unchanged inputs SHALL be idempotent, because of the ID match rule.
REQ-018 Best-entry selection SHALL be combinational over the valid entries:
  - highest Q wins;
  - on equal Q, fewer hops wins;
  - on equal hops, lower slot index wins.
REQ-019 chosenCH and hopsfromCH SHALL be registered from the selection result every cycle that HB_reset=0.
REQ-020 Output latency SHALL be: table written at edge N, outputs reflect the result at edge N+1.
REQ-021 With no valid entries, both outputs SHALL be 0xFFFF.
REQ-022 HB_reset asserted together with en_KCH SHALL win; the fCH_* sample SHALL be dropped.
REQ-023 HB_reset held for multiple cycles SHALL keep the table empty and the outputs at 0xFFFF.
REQ-024 All comparisons SHALL be unsigned 16-bit; no arithmetic overflow is possible.

Reset
REQ-025 nrst=1 at an edge SHALL:
  - clear all valid bits and the count;
  - clear the limit to 0;
  - set chosenCH = hopsfromCH = 0xFFFF.
REQ-026 nrst SHALL take priority over HB_reset and en_KCH.
REQ-027 nrst asserted mid-operation SHALL discard all entries; no CH is accepted until a subsequent HB_reset loads a limit.

Structure
REQ-028 Package known_ch_pkg SHALL hold:
  - WORD_WIDTH and MAX_CH;
  - NO_CH = 16'hFFFF;
  - the ch_entry_t struct {valid, id, hops, q}.
REQ-029 Selection logic SHALL be one sub-module, known_ch_best_sel, taking the entry array and returning {found, id, hops}.
REQ-030 Table update, limit and output registers SHALL reside in known_ch_v3.

Verification
REQ-031 Reset: nrst=1 for one cycle, then en_KCH pulses with no HB_reset -> outputs stay 0xFFFF, nothing stored.
REQ-032 Basic insert:
  - HB_reset, limit 3;
  - ID 23, hops 2, Q 0x3000, en_KCH for 2 cycles -> chosenCH=23, hopsfromCH=2 one cycle later; count=1;
  - then ID 45, hops 2, Q 0x2000 -> chosenCH stays 23; count=2.
REQ-033 Tie-break:
  - ID 10, hops 3, Q 0x2000, then ID 11, hops 1, Q 0x2000 -> chosenCH=11, hops 1;
  - then ID 9, hops 1, Q 0x2000 -> chosenCH stays 11 (lower slot).
REQ-034 Limit and full:
  - limit 2; insert IDs 1 (Q 0x1000) and 2 (Q 0x1800); then ID 3, Q 0x3F00 -> ignored; chosenCH=2;
  - limit 0 -> all ignored; outputs 0xFFFF;
  - HB_CHlimit=100 -> limit clamps to 16.
REQ-035 Update and priority:
  - re-send ID 23 with Q 0x0800 while 45 holds 0x2000 -> chosenCH=45;
  - HB_reset together with en_KCH -> table empty; outputs 0xFFFF.
